// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1 plus one spare bit for the post-increment.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/product handshake bundle for seq_mult.
// SEQ_MULT_SIGNED_EN adds the signed_mode operand qualifier.
interface seq_mult_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 signed_mode;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
`endif

endinterface

// File: rtl/seq_mult_adder_n.sv
// N-bit ripple-carry adder; used for the accumulate step and for
// two's-complement negation (invert, then add one).
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ w_carry[i];
        assign w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
    end

    assign cout = w_carry[N];

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one partial product per clock, with
// valid/ready on both sides. SEQ_MULT_SIGNED_EN enables two's-complement mode.
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_mult_if.slave  bus
);

    localparam int                CNT_W    = calc_cnt_w(WIDTH);
    localparam int                PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [PW-1:0]      r_product;
    logic [PW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_operand_zero;
    logic [PW-1:0]      w_addend;
    logic [PW-1:0]      w_sum;
    logic [PW-1:0]      w_result;
    logic               w_unused_acc_cout;

    // Partial product for the current multiplier bit.
    always_comb begin
        w_operand_zero = (bus.a == {WIDTH{1'b0}}) || (bus.b == {WIDTH{1'b0}});
        if (r_mplier[0]) begin
            w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
        end else begin
            w_addend = {PW{1'b0}};
        end
    end

    adder_n #(.N(PW)) u_acc_add (
        .x    (r_acc),
        .y    (w_addend),
        .sum  (w_sum),
        .cout (w_unused_acc_cout)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic               w_a_neg;
    logic               w_b_neg;
    logic               r_neg;
    logic [PW-1:0]      w_neg_sum;
    logic               w_unused_neg_cout;

    // Magnitudes feed the unsigned loop; -2^(WIDTH-1) maps onto itself.
    always_comb begin
        w_a_neg = bus.signed_mode & bus.a[WIDTH-1];
        w_b_neg = bus.signed_mode & bus.b[WIDTH-1];
        if (w_a_neg) begin
            w_a_mag = ~bus.a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_a_mag = bus.a;
        end
        if (w_b_neg) begin
            w_b_mag = ~bus.b + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_b_mag = bus.b;
        end
    end

    adder_n #(.N(PW)) u_negate (
        .x    (~w_sum),
        .y    ({{(PW-1){1'b0}}, 1'b1}),
        .sum  (w_neg_sum),
        .cout (w_unused_neg_cout)
    );

    // Apply the sign on the final accumulate.
    always_comb begin
        if (r_neg) begin
            w_result = w_neg_sum;
        end else begin
            w_result = w_sum;
        end
    end
`else
    // Unsigned operands pass straight through.
    always_comb begin
        w_a_mag  = bus.a;
        w_b_mag  = bus.b;
        w_result = w_sum;
    end
`endif

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= {PW{1'b0}};
            r_acc       <= {PW{1'b0}};
            r_mcand     <= {WIDTH{1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            r_neg       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand    <= w_a_mag;
                        r_mplier   <= w_b_mag;
                        r_in_ready <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
                        r_neg      <= w_a_neg ^ w_b_neg;
`endif
                        if (w_operand_zero) begin
                            r_product   <= {PW{1'b0}};
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_acc   <= {PW{1'b0}};
                            r_cnt   <= {CNT_W{1'b0}};
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc    <= w_sum;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST_CNT) begin
                        r_product   <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: WIDTH=4 and WIDTH=8 instances checked
// against arithmetic reference values; signed cases under SEQ_MULT_SIGNED_EN.
module tb_seq_mult;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_mult_if #(.WIDTH(4)) if4 ();
    seq_mult_if #(.WIDTH(8)) if8 ();

    seq_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    seq_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        int lat;
        int exp_p;
        int exp_lat;
        if (sm) exp_p = int'($signed(a)) * int'($signed(b));
        else    exp_p = int'(a) * int'(b);
        exp_lat = (a == 4'd0 || b == 4'd0) ? 0 : 4;
        @(negedge clk);
        if4.a = a; if4.b = b; if4.in_valid = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        if4.signed_mode = sm;
`endif
        chk("rdy4", if4.in_ready, 1);
        @(negedge clk);
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("lat4", lat, exp_lat);
        chk("prod4", if4.product, exp_p[7:0]);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        chk("rel4", {if4.out_valid, if4.in_ready}, 2'b01);
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        int exp_p;
        int exp_lat;
        exp_p   = int'(a) * int'(b);
        exp_lat = (a == 8'd0 || b == 8'd0) ? 0 : 8;
        @(negedge clk);
        if8.a = a; if8.b = b; if8.in_valid = 1'b1;
        chk("rdy8", if8.in_ready, 1);
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("lat8", lat, exp_lat);
        chk("prod8", if8.product, exp_p[15:0]);
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        chk("rel8", {if8.out_valid, if8.in_ready}, 2'b01);
    endtask

    initial begin
        int          sent;
        int          recv;
        int          cyc;
        int          gap;
        int          wait_cnt;
        logic        fired;
        logic [15:0] q[$];
        logic [15:0] e;

        rst = 1'b1;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = 4'd0; if4.b = 4'd0;
        if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = 8'd0; if8.b = 8'd0;
`ifdef SEQ_MULT_SIGNED_EN
        if4.signed_mode = 1'b0;
        if8.signed_mode = 1'b0;
`endif
        #2;
        chk("rst_rdy", {if8.in_ready, if4.in_ready}, 2'b11);
        chk("rst_vld", {if8.out_valid, if4.out_valid}, 2'b00);
        chk("rst_prod", if8.product, 0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive unsigned WIDTH=4
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                mul4(4'(i), 4'(j), 1'b0);

`ifdef SEQ_MULT_SIGNED_EN
        mul4(4'h8, 4'h8, 1'b1);
        mul4(4'h8, 4'h7, 1'b1);
        mul4(4'h3, 4'hF, 1'b1);
        mul4(4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                mul4(4'(i), 4'(j), 1'b1);
`endif

        mul8(8'd0, 8'd37);
        mul8(8'd37, 8'd0);
        mul8(8'd255, 8'd255);

        // Backpressure: result held, new operands ignored while in DONE
        @(negedge clk);
        if8.a = 8'd13; if8.b = 8'd11; if8.in_valid = 1'b1;
        @(negedge clk);
        wait_cnt = 0;
        while (!if8.out_valid && wait_cnt < 30) begin
            @(negedge clk);
            wait_cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            if8.a = 8'($urandom); if8.b = 8'($urandom); if8.in_valid = 1'b1;
            chk("bp_vld", if8.out_valid, 1);
            chk("bp_rdy", if8.in_ready, 0);
            chk("bp_prod", if8.product, 143);
            @(negedge clk);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        chk("bp_idle", {if8.out_valid, if8.in_ready}, 2'b01);
        mul8(8'd2, 8'd3);

        // Reset mid-calculation: previous product (6) must clear immediately
        @(negedge clk);
        if8.a = 8'd200; if8.b = 8'd3; if8.in_valid = 1'b1;
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mrst_vld", if8.out_valid, 0);
        chk("mrst_rdy", if8.in_ready, 1);
        chk("mrst_prod", if8.product, 0);
        @(negedge clk);
        rst = 1'b0;
        mul8(8'd12, 8'd12);

        // Randomised traffic with gaps and backpressure, queue-based scoreboard
        sent = 0; recv = 0; cyc = 0; gap = 0; fired = 1'b0;
        while (recv < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if8.out_ready = ($urandom_range(0, 3) != 0);
            if (if8.out_valid && if8.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_prod", if8.product, e);
                end
                recv++;
            end
            if (fired) begin
                if8.in_valid = 1'b0;
                gap = $urandom_range(0, 2);
            end
            if (!if8.in_valid && sent < 1000) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    if8.a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
                    if8.b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
                    if8.in_valid = 1'b1;
                    sent++;
                end
            end
            fired = if8.in_valid && if8.in_ready;
            if (fired) begin
                e = {8'h00, if8.a} * {8'h00, if8.b};
                q.push_back(e);
            end
        end
        if8.out_ready = 1'b0;
        if8.in_valid  = 1'b0;
        chk("rnd_recv", recv, 1000);
        chk("rnd_left", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
